// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if
// Handshake bundle for the FFT bit-reversal reorder buffer.
//   in_valid/in_data/in_ready : sample stream from the last butterfly stage
//   out_valid/out_ready       : natural-order stream to the consumer
//   out_data/out_index/out_last : sample, its natural bin index, end-of-frame flag
// The master modport is the producer/consumer side; slave is the reorder block.
interface fft_bitrev_reorder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2N      = 6
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LOG2N-1:0]      out_index;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Collects one N-point frame delivered in bit-reversed bin order into a
// ping-pong buffer and replays it in natural bin order.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (control state and outputs only)
//   bus   : fft_bitrev_reorder_if.slave handshake bundle
// The write side fills bank wbank at address bitrev(wcnt); the read side drains
// bank rbank sequentially into a registered output stage. A bank's full flag
// hands it from writer to reader and back, so both sides never touch the same
// bank in one cycle.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2N      = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  fft_bitrev_reorder_if.slave bus
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] IDX_ZERO = {LOG2N{1'b0}};
  localparam logic [LOG2N-1:0] IDX_LAST = {LOG2N{1'b1}};
  localparam logic [LOG2N-1:0] IDX_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};

  // Reverse the LOG2N bits of an index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    r = IDX_ZERO;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [2][N];

  logic [1:0]            full_r;
  logic [1:0]            full_nxt_s;
  logic                  wbank_r;
  logic [LOG2N-1:0]      wcnt_r;
  logic                  rbank_r;
  logic [LOG2N-1:0]      rcnt_r;

  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [LOG2N-1:0]      out_index_r;
  logic                  out_last_r;

  logic                  in_ready_s;
  logic                  wr_fire_s;
  logic                  wr_wrap_s;
  logic                  load_s;
  logic                  rd_wrap_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Handshake decode: writer stalls only on its own bank being full; the
  // output stage reloads whenever it is empty or being consumed.
  always_comb begin
    in_ready_s = ~full_r[wbank_r];
    wr_fire_s  = bus.in_valid & in_ready_s;
    wr_wrap_s  = wr_fire_s & (wcnt_r == IDX_LAST);
    load_s     = full_r[rbank_r] & (~out_valid_r | bus.out_ready);
    rd_wrap_s  = load_s & (rcnt_r == IDX_LAST);
    rd_data_s  = mem_r[rbank_r][rcnt_r];
  end

  // Full-flag update: set and clear always address different banks, so
  // applying both in sequence is order-independent.
  always_comb begin
    full_nxt_s = full_r;
    if (wr_wrap_s) begin
      full_nxt_s[wbank_r] = 1'b1;
    end else begin
      full_nxt_s[wbank_r] = full_r[wbank_r];
    end
    if (rd_wrap_s) begin
      full_nxt_s[rbank_r] = 1'b0;
    end else begin
      full_nxt_s[rbank_r] = full_nxt_s[rbank_r];
    end
  end

  // Sample storage, written in scrambled order; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wbank_r][bitrev(wcnt_r)] <= bus.in_data;
    end
  end

  // Write-side bank/count tracking and full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r  <= 2'b00;
      wbank_r <= 1'b0;
      wcnt_r  <= IDX_ZERO;
    end else begin
      full_r <= full_nxt_s;
      if (wr_wrap_s) begin
        wbank_r <= ~wbank_r;
        wcnt_r  <= IDX_ZERO;
      end else if (wr_fire_s) begin
        wcnt_r <= wcnt_r + IDX_ONE;
      end
    end
  end

  // Read-side bank/count tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbank_r <= 1'b0;
      rcnt_r  <= IDX_ZERO;
    end else begin
      if (rd_wrap_s) begin
        rbank_r <= ~rbank_r;
        rcnt_r  <= IDX_ZERO;
      end else if (load_s) begin
        rcnt_r <= rcnt_r + IDX_ONE;
      end
    end
  end

  // Output stage: load a natural-order word, hold it under backpressure,
  // drop valid once consumed with nothing new to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_index_r <= IDX_ZERO;
      out_last_r  <= 1'b0;
    end else begin
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= rd_data_s;
        out_index_r <= rcnt_r;
        out_last_r  <= (rcnt_r == IDX_LAST);
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_index = out_index_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder
// Drives an N=8 instance through directed corner cases and an N=64 instance
// with random handshakes; both are scored against a frame-level model that
// stores arriving samples and emits frame[bitrev(n)] for n = 0..N-1.
module tb_fft_bitrev_reorder;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .LOG2N(3)) if3 ();
  fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .LOG2N(6)) if6 ();

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  fft_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2N(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] d; int idx; } exp_t;
  typedef struct { logic [31:0] din; logic [31:0] dout; int idx; logic last; } vec_t;

  // N=8 model state
  logic [31:0] cur3[$];
  exp_t        exp3[$];
  logic [31:0] got3[$];
  int outs3, acc3, ir_low3, cyc3_no, first_v3, last_v3;
  logic hold3; logic [31:0] hd3; logic [2:0] hi3; logic hl3;

  // N=64 model state
  logic [31:0] cur6[$];
  exp_t        exp6[$];
  int outs6, acc6;
  logic hold6; logic [31:0] hd6; logic [5:0] hi6; logic hl6;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int brev(input int x, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if ((x >> i) & 1) r |= 1 << (bits - 1 - i);
    return r;
  endfunction

  // One clock of the N=8 instance with scoreboarding.
  task automatic cyc3(input logic iv, input logic [31:0] id, input logic ordy);
    logic inf, outf, ol; logic [31:0] od; logic [2:0] oi; exp_t e;
    if (hold3) begin
      check("hold3_valid", if3.out_valid, 1);
      check("hold3_fields", {if3.out_last, if3.out_index, if3.out_data}, {hl3, hi3, hd3});
    end
    if3.in_valid = iv; if3.in_data = id; if3.out_ready = ordy;
    inf  = iv & if3.in_ready;
    outf = if3.out_valid & ordy;
    if (iv && !if3.in_ready) ir_low3++;
    od = if3.out_data; oi = if3.out_index; ol = if3.out_last;
    hold3 = if3.out_valid & !ordy; hd3 = od; hi3 = oi; hl3 = ol;
    if (outf) begin
      if (first_v3 < 0) first_v3 = cyc3_no;
      last_v3 = cyc3_no;
    end
    @(posedge clk); #1;
    cyc3_no++;
    if (inf) begin
      acc3++;
      cur3.push_back(id);
      if (cur3.size() == 8) begin
        for (int n = 0; n < 8; n++) exp3.push_back('{cur3[brev(n, 3)], n});
        cur3.delete();
      end
    end
    if (outf) begin
      outs3++;
      got3.push_back(od);
      if (exp3.size() == 0) begin
        total++; bad++;
        $display("FAIL extra3: unexpected output %0h idx %0d, expected none", od, oi);
      end else begin
        e = exp3.pop_front();
        check("data3", od, e.d);
        check("idx3", oi, e.idx);
        check("last3", ol, e.idx == 7);
      end
    end
  endtask

  // One clock of the N=64 instance with scoreboarding.
  task automatic cyc6(input logic iv, input logic [31:0] id, input logic ordy);
    logic inf, outf, ol; logic [31:0] od; logic [5:0] oi; exp_t e;
    if (hold6) begin
      check("hold6_valid", if6.out_valid, 1);
      check("hold6_fields", {if6.out_last, if6.out_index, if6.out_data}, {hl6, hi6, hd6});
    end
    if6.in_valid = iv; if6.in_data = id; if6.out_ready = ordy;
    inf  = iv & if6.in_ready;
    outf = if6.out_valid & ordy;
    od = if6.out_data; oi = if6.out_index; ol = if6.out_last;
    hold6 = if6.out_valid & !ordy; hd6 = od; hi6 = oi; hl6 = ol;
    @(posedge clk); #1;
    if (inf) begin
      acc6++;
      cur6.push_back(id);
      if (cur6.size() == 64) begin
        for (int n = 0; n < 64; n++) exp6.push_back('{cur6[brev(n, 6)], n});
        cur6.delete();
      end
    end
    if (outf) begin
      outs6++;
      if (exp6.size() == 0) begin
        total++; bad++;
        $display("FAIL extra6: unexpected output %0h idx %0d, expected none", od, oi);
      end else begin
        e = exp6.pop_front();
        check("data6", od, e.d);
        check("idx6", oi, e.idx);
        check("last6", ol, e.idx == 63);
      end
    end
  endtask

  task automatic drain3(input int maxc);
    int c = 0;
    while ((exp3.size() != 0 || if3.out_valid) && c < maxc) begin
      cyc3(1'b0, 32'd0, 1'b1); c++;
    end
    check("drain3_left", exp3.size(), 0);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", if3.out_valid, 0);
    check("rst_in_ready", if3.in_ready, 1);
    check("rst_out_fields", {if3.out_last, if3.out_index, if3.out_data}, 0);
    check("rst6_out_valid", if6.out_valid, 0);
    cur3.delete(); exp3.delete(); got3.delete(); hold3 = 1'b0;
    cur6.delete(); exp6.delete(); hold6 = 1'b0;
    outs3 = 0; acc3 = 0; ir_low3 = 0; first_v3 = -1; last_v3 = -1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", if3.in_ready, 1);
  endtask

  vec_t tbl[8];
  int c;

  initial begin
    tbl[0] = '{32'd0, 32'd0, 0, 1'b0};
    tbl[1] = '{32'd1, 32'd4, 1, 1'b0};
    tbl[2] = '{32'd2, 32'd2, 2, 1'b0};
    tbl[3] = '{32'd3, 32'd6, 3, 1'b0};
    tbl[4] = '{32'd4, 32'd1, 4, 1'b0};
    tbl[5] = '{32'd5, 32'd5, 5, 1'b0};
    tbl[6] = '{32'd6, 32'd3, 6, 1'b0};
    tbl[7] = '{32'd7, 32'd7, 7, 1'b1};
    cyc3_no = 0; outs6 = 0; acc6 = 0;
    if3.in_valid = 1'b0; if3.in_data = 32'd0; if3.out_ready = 1'b0;
    if6.in_valid = 1'b0; if6.in_data = 32'd0; if6.out_ready = 1'b0;
    reset_all();

    // Basic reorder with latency check
    for (int i = 0; i < 8; i++) cyc3(1'b1, tbl[i].din, 1'b1);
    check("latency_e_valid", if3.out_valid, 0);
    cyc3(1'b0, 32'd0, 1'b1);
    check("latency_e1_valid", if3.out_valid, 1);
    check("latency_e1_index", if3.out_index, 0);
    drain3(40);
    check("basic_count", got3.size(), 8);
    for (int i = 0; i < 8 && i < got3.size(); i++) check("basic_tbl", got3[i], tbl[i].dout);

    // Streaming, four back-to-back frames
    reset_all();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 8; k++) cyc3(1'b1, 32'(8 * f + k), 1'b1);
    drain3(40);
    check("stream_in_ready_low", ir_low3, 0);
    check("stream_outs", outs3, 32);
    check("stream_span", last_v3 - first_v3 + 1, 32);

    // Full backpressure
    reset_all();
    for (int i = 0; i < 30; i++) cyc3(1'b1, 32'(acc3), 1'b0);
    check("bp_accepted", acc3, 16);
    check("bp_in_ready", if3.in_ready, 0);
    check("bp_out_valid", if3.out_valid, 1);
    check("bp_out_data", if3.out_data, 0);
    cyc3(1'b1, 32'(acc3), 1'b1);
    check("bp_pulse_in_ready", if3.in_ready, 0);
    c = 0;
    while (!if3.in_ready && c < 20) begin cyc3(1'b0, 32'd0, 1'b1); c++; end
    check("bp_reads_to_ready", c, 6);
    c = 0;
    while (acc3 < 24 && c < 40) begin cyc3(1'b1, 32'(acc3), 1'b1); c++; end
    drain3(60);
    check("bp_outs", outs3, 24);

    // Partial frame stays pending
    reset_all();
    for (int k = 0; k < 5; k++) cyc3(1'b1, 32'(100 + k), 1'b1);
    for (int i = 0; i < 50; i++) cyc3(1'b0, 32'd0, 1'b1);
    check("partial_no_out", outs3, 0);
    for (int k = 5; k < 8; k++) cyc3(1'b1, 32'(100 + k), 1'b1);
    drain3(40);
    check("partial_outs", outs3, 8);

    // Reset while emitting index 3 with 5 samples of the next frame pending
    reset_all();
    for (int k = 0; k < 8; k++) cyc3(1'b1, 32'(200 + k), 1'b0);
    for (int k = 0; k < 5; k++) cyc3(1'b1, 32'(300 + k), 1'b0);
    for (int i = 0; i < 3; i++) cyc3(1'b0, 32'd0, 1'b1);
    check("midrst_index", if3.out_index, 3);
    reset_all();
    for (int k = 0; k < 8; k++) cyc3(1'b1, 32'(400 + k), 1'b1);
    drain3(40);
    check("midrst_outs", outs3, 8);

    // Random handshakes on the N=64 instance, 20 frames
    c = 0;
    while (acc6 < 1280 && c < 20000) begin
      cyc6(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      c++;
    end
    c = 0;
    while ((exp6.size() != 0 || if6.out_valid) && c < 5000) begin
      cyc6(1'b0, 32'd0, 1'($urandom_range(0, 1)));
      c++;
    end
    check("rand_accepted", acc6, 1280);
    check("rand_outs", outs6, 1280);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer for the streaming radix-2 FFT pipeline. The last butterfly stage emits each N-point frame in bit-reversed index order. This block collects a frame in a ping-pong buffer and replays it in natural index order with a valid/ready handshake. It sits between the final FFT stage and the downstream consumer and sustains one sample per cycle when the consumer never stalls.

## Interface
- DATA_WIDTH, 32: width of one complex sample ({re, im} packed, opaque to this block)
- LOG2N, 6: log2 of frame length N (N = 64 by default); legal range 2..12
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_data  in  DATA_WIDTH  input sample; the k-th accepted sample of a frame carries FFT bin bitrev(k)
- in_ready  out  1  block can accept a sample this cycle
- out_valid  out  1  out_data/out_index/out_last valid
- out_ready  in  1  consumer accepts the output this cycle
- out_data  out  DATA_WIDTH  sample in natural bin order
- out_index  out  LOG2N  natural bin index of out_data (0..N-1)
- out_last  out  1  high with out_index == N-1

## Operation
- Storage is two banks of N words (bank0, bank1), each with a full flag.
- Write side:
  - wbank (1 bit) and wcnt (LOG2N bits).
  - Input transfer = in_valid & in_ready.
  - in_ready = !full[wbank] (combinational, no dependence on in_valid).
  - On each transfer: mem[wbank][bitrev(wcnt)] <= in_data; wcnt++.
  - On the transfer with wcnt == N-1: set full[wbank], toggle wbank, wcnt <= 0.
- Read side:
  - rbank and rcnt.
  - Output register load condition: load = full[rbank] & (!out_valid | out_ready).
  - On load: out_data <= mem[rbank][rcnt]; out_index <= rcnt; out_last <= (rcnt == N-1); out_valid <= 1; rcnt++.
  - On a load with rcnt == N-1: clear full[rbank], toggle rbank, rcnt <= 0.
  - When out_valid & out_ready & !load: out_valid <= 0.
- Output hold: while out_valid & !out_ready, out_data, out_index and out_last hold their values.
- Simultaneous events:
  - Set and clear of full flags always target different banks, because the writer never writes a full bank. Both take effect on the same edge.
  - A write and a read in the same cycle always hit different banks.
- bitrev(x) reverses the LOG2N bits of x: bit i maps to bit LOG2N-1-i.
- Frames are accepted and emitted strictly in order. No frame is dropped or duplicated.
- Memory contents are not reset. Only the control state and output registers are reset.

## Timing
- Reset values: out_valid 0, out_data 0, out_index 0, out_last 0; full[1:0] = 0; wbank = rbank = 0; wcnt = rcnt = 0; in_ready = 1.
- Latency: if the last sample of a frame is accepted at edge E and the read bank is idle, out_valid is first high after edge E+1, carrying index 0.
- Throughput: with out_ready held 1 and in_valid held 1, in_ready never deasserts after the first frame and there are no output bubbles within or between frames.
  - Reasoning: the clear of full[b] at read edge E+N frees bank b just as the writer wraps to it.
- Backpressure: if both banks are full, in_ready = 0 until the reader issues the load of word N-1 from rbank. in_ready rises in the cycle after that edge.
- A partial frame (wcnt != 0) is never emitted. It stays pending until N samples have arrived.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Partial and pending frames are discarded, and the first accepted sample after reset is bitrev index 0 of a new frame.

## Test plan
- Basic reorder, LOG2N=3:
  - Stimulus: in_data = k for k = 0..7, in_valid continuous, out_ready = 1.
  - Required: out_data sequence 0,4,2,6,1,5,3,7; out_index 0..7; out_last only on the 8th output; first out_valid one cycle after the 8th input edge.
- Streaming, LOG2N=3:
  - Stimulus: 4 back-to-back frames with in_data = 8*f + k.
  - Required: in_ready stays 1 throughout; 32 consecutive out_valid cycles with no gap; frame f outputs 8*f + bitrev(n).
- Full backpressure, LOG2N=3:
  - Stimulus: out_ready = 0, feed 3 frames.
  - Required: in_ready drops after 16 accepted samples; out_valid = 1 with out_data = 0 held stable.
  - Then raise out_ready for 1 cycle: in_ready stays 0. After 8 reads, in_ready returns to 1.
- Random stall, LOG2N=6:
  - Stimulus: in_valid and out_ready each random at 50%, 20 frames.
  - Required: scoreboard matches natural-order data exactly; out_* stable whenever out_valid & !out_ready.
- Partial frame:
  - Stimulus: LOG2N=3, feed 5 samples then idle 50 cycles.
  - Required: out_valid stays 0. After 3 more samples, the frame emits correctly.
- Reset mid-frame:
  - Stimulus: assert rst_n low while emitting frame index 3 of 8, with 5 samples of the next frame pending.
  - Required: out_valid = 0 and in_ready = 1 immediately. A fresh frame afterwards reorders correctly, with no stale output.
